// File: rtl/ysyx_22041207_mul.sv
// ----------------------------------------------------------------------------
// ysyx_22041207_mul_ctrl
//   Sequencer between the EXU and the iterative multiplier ysyx_22041207_mul.
//   Accepts MUL/MULW requests, launches the multiplier only when it is free,
//   short-circuits zero operands and repeated operand pairs, applies the
//   MULW sign extension, holds the result under writeback backpressure, and
//   recovers the multiplier after a pipeline flush.
//
// Parameters
//   ZERO_BYPASS  1: a request with a zero operand completes without the multiplier
//   CACHE_EN     1: one-entry last-operand/result cache enabled
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               pipeline flush, kills any in-flight request
//   req_*               EXU request channel (valid/ready, w, src1, src2, rd)
//   resp_*              writeback channel (valid/ready, data, rd)
//   mul_valid/flush     start pulse / flush line to the multiplier
//   mul_multiplicand    operand a, held stable until sampled
//   mul_multiplier      operand b, held stable until sampled
//   mul_ready           multiplier idle
//   mul_out_valid       one-cycle completion pulse
//   mul_result_hi/lo    product[63:32] / product[31:0]
// ----------------------------------------------------------------------------
module ysyx_22041207_mul_ctrl #(
   parameter int ZERO_BYPASS = 1,
   parameter int CACHE_EN    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_w,
   input  logic [63:0] req_src1,
   input  logic [63:0] req_src2,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        mul_valid,
   output logic        mul_flush,
   output logic [63:0] mul_multiplicand,
   output logic [63:0] mul_multiplier,
   input  logic        mul_ready,
   input  logic        mul_out_valid,
   input  logic [31:0] mul_result_hi,
   input  logic [31:0] mul_result_lo
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state, state_nxt;

   // dirty: the multiplier may still be busy with (or stalled on) a killed op
   logic        dirty, dirty_nxt;

   logic [63:0] src1, src2, product;
   logic        w;
   logic [4:0]  rd;

   logic        cache_valid;
   logic [63:0] c_src1, c_src2, c_prod;

   logic        accept;
   logic        zero_hit;
   logic        cache_hit;
   logic        issue_fire;
   logic        mul_done;

   // ------------------------------------------------------------------------
   // Handshake and path decode
   // ------------------------------------------------------------------------
   always_comb begin
      req_ready  = (state == IDLE) && !flush;
      accept     = req_valid && req_ready;
      zero_hit   = (ZERO_BYPASS != 0) && ((req_src1 == '0) || (req_src2 == '0));
      cache_hit  = (CACHE_EN != 0) && cache_valid &&
                   (req_src1 == c_src1) && (req_src2 == c_src2);
      // A dirty multiplier is restarted with flush+valid regardless of
      // mul_ready; a clean one is started only once it reports idle. Never
      // start in a cycle carrying a completion pulse.
      issue_fire = (state == ISSUE) && !flush && !mul_out_valid &&
                   (dirty || mul_ready);
      mul_done   = (state == WAIT) && mul_out_valid && !flush;
   end

   // ------------------------------------------------------------------------
   // Next state / dirty tracking
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      dirty_nxt = dirty;

      case (state)
         IDLE:  if (accept)        state_nxt = (zero_hit || cache_hit) ? DONE : ISSUE;
         ISSUE: if (issue_fire)    state_nxt = WAIT;
         WAIT:  if (mul_out_valid) state_nxt = DONE;
         DONE:  if (resp_ready)    state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase

      if (issue_fire) begin
         dirty_nxt = 1'b0;
      end

      // Any completion pulse leaves the multiplier idle, whether it belonged
      // to the live op or a killed one; otherwise a flush while the
      // multiplier is engaged leaves it in an unknown busy state.
      if (mul_out_valid) begin
         dirty_nxt = 1'b0;
      end else if (flush && ((state == ISSUE) || (state == WAIT))) begin
         dirty_nxt = 1'b1;
      end

      if (flush) begin
         state_nxt = IDLE;
      end
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dirty   <= 1'b0;
         src1    <= '0;
         src2    <= '0;
         product <= '0;
         w       <= 1'b0;
         rd      <= '0;
      end else begin
         state <= state_nxt;
         dirty <= dirty_nxt;

         if (accept) begin
            src1 <= req_src1;
            src2 <= req_src2;
            w    <= req_w;
            rd   <= req_rd;
            if (zero_hit) begin
               product <= '0;
            end else if (cache_hit) begin
               product <= c_prod;
            end
         end

         if (mul_done) begin
            product <= {mul_result_hi, mul_result_lo};
         end
      end
   end

   // ------------------------------------------------------------------------
   // One-entry operand/result cache, written only by real multiplier results
   // ------------------------------------------------------------------------
   generate
      if (CACHE_EN != 0) begin : g_cache
         always_ff @(posedge clk) begin
            if (rst) begin
               cache_valid <= 1'b0;
               c_src1      <= '0;
               c_src2      <= '0;
               c_prod      <= '0;
            end else if (mul_done) begin
               cache_valid <= 1'b1;
               c_src1      <= src1;
               c_src2      <= src2;
               c_prod      <= {mul_result_hi, mul_result_lo};
            end
         end
      end else begin : g_no_cache
         always_comb begin
            cache_valid = 1'b0;
            c_src1      = '0;
            c_src2      = '0;
            c_prod      = '0;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      resp_valid       = (state == DONE);
      resp_data        = w ? {{32{product[31]}}, product[31:0]} : product;
      resp_rd          = rd;
      mul_valid        = issue_fire;
      mul_flush        = flush || (issue_fire && dirty);
      mul_multiplicand = src1;
      mul_multiplier   = src2;
   end

endmodule

// File: tb/tb_ysyx_22041207_mul_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041207_mul_ctrl
//   Bench for the multiplier sequencer. A behavioural multiplier stub answers
//   the mul_* interface; expected results, bypass decisions and latencies come
//   from a transaction-level reference model (product arithmetic plus a
//   one-entry last-pair record).
// ----------------------------------------------------------------------------
module tb_ysyx_22041207_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic        req_w;
   logic [63:0] req_src1;
   logic [63:0] req_src2;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        mul_valid;
   logic        mul_flush;
   logic [63:0] mul_multiplicand;
   logic [63:0] mul_multiplier;
   logic        mul_ready;
   logic        mul_out_valid;
   logic [31:0] mul_result_hi;
   logic [31:0] mul_result_lo;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_22041207_mul_ctrl #(
      .ZERO_BYPASS (1),
      .CACHE_EN    (1)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_w            (req_w),
      .req_src1         (req_src1),
      .req_src2         (req_src2),
      .req_rd           (req_rd),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_data        (resp_data),
      .resp_rd          (resp_rd),
      .mul_valid        (mul_valid),
      .mul_flush        (mul_flush),
      .mul_multiplicand (mul_multiplicand),
      .mul_multiplier   (mul_multiplier),
      .mul_ready        (mul_ready),
      .mul_out_valid    (mul_out_valid),
      .mul_result_hi    (mul_result_hi),
      .mul_result_lo    (mul_result_lo)
   );

   // ------------------------------------------------------------------------
   // Multiplier stub: starts on mul_valid (a flush alone leaves it running),
   // completion pulse 65 cycles after the start edge.
   // ------------------------------------------------------------------------
   logic        m_busy;
   int          m_cnt;
   logic [63:0] m_a, m_b, m_p;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else if (mul_valid) begin
         m_busy <= 1'b1;
         m_cnt  <= 0;
         m_a    <= mul_multiplicand;
         m_b    <= mul_multiplier;
      end else if (m_busy) begin
         if (m_cnt == 65) m_busy <= 1'b0;
         else             m_cnt  <= m_cnt + 1;
      end
   end

   always_comb begin
      m_p           = m_a * m_b;
      mul_ready     = !m_busy;
      mul_out_valid = m_busy && (m_cnt == 65);
      mul_result_hi = m_p[63:32];
      mul_result_lo = m_p[31:0];
   end

   // Interface event counters
   int mv_count  = 0;
   int vf_count  = 0;
   int ovl_count = 0;

   always @(posedge clk) begin
      if (!rst) begin
         if (mul_valid)                  mv_count  <= mv_count + 1;
         if (mul_valid && mul_flush)     vf_count  <= vf_count + 1;
         if (mul_valid && mul_out_valid) ovl_count <= ovl_count + 1;
      end
   end

   // ------------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------------
   logic        mc_valid = 1'b0;
   logic [63:0] mc_a = '0;
   logic [63:0] mc_b = '0;
   logic        mv_after;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic w, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] p;
      p = a * b;
      return w ? {{32{p[31]}}, p[31:0]} : p;
   endfunction

   function automatic logic ref_bypass(input logic [63:0] a, input logic [63:0] b);
      return (a == 64'd0) || (b == 64'd0) || (mc_valid && (a == mc_a) && (b == mc_b));
   endfunction

   // Ends at the falling edge right after the acceptance edge.
   task automatic accept_req(input logic w, input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] rd);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_w     = w;
      req_src1  = a;
      req_src2  = b;
      req_rd    = rd;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      mv_after = mul_valid;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 300);
      if (!resp_valid) check("resp_timeout", 64'd0, 64'd1);
   endtask

   task automatic take_resp(input int hold);
      logic [63:0] d0;
      logic [4:0]  r0;
      d0 = resp_data;
      r0 = resp_rd;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_valid", 64'(resp_valid), 64'd1);
         check("bp_data",  resp_data, d0);
         check("bp_rd",    64'(resp_rd), 64'(r0));
         check("bp_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check("taken_valid", 64'(resp_valid), 64'd0);
      check("taken_ready", 64'(req_ready), 64'd1);
   endtask

   task automatic run_txn(input logic w, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int hold);
      logic        byp;
      logic [63:0] exp;
      int          lat;
      byp = ref_bypass(a, b);
      exp = ref_res(w, a, b);
      accept_req(w, a, b, rd);
      check("mv_after_accept", 64'(mv_after), byp ? 64'd0 : 64'd1);
      wait_resp(lat);
      check("latency", 64'(lat), byp ? 64'd1 : 64'd67);
      check("data", resp_data, exp);
      check("rd", 64'(resp_rd), 64'(rd));
      take_resp(hold);
      if (!byp) begin
         mc_valid = 1'b1;
         mc_a     = a;
         mc_b     = b;
      end
   endtask

   // Request killed by a flush r cycles after acceptance, then drained.
   task automatic flush_txn(input logic w, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd, input int r);
      logic byp;
      byp = ref_bypass(a, b);
      accept_req(w, a, b, rd);
      repeat (r) @(negedge clk);
      flush = 1'b1;
      #1;
      check("fl_mul_flush", 64'(mul_flush), 64'd1);
      check("fl_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("fl_resp_valid", 64'(resp_valid), 64'd0);
      check("fl_idle_ready", 64'(req_ready), 64'd1);
      // the result reaches the cache only if it completed before the flush cycle
      if (!byp && r >= 67) begin
         mc_valid = 1'b1;
         mc_a     = a;
         mc_b     = b;
      end
      repeat (70) @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int          mv0;
      int          vf0;
      logic [63:0] a, b, last_a, last_b;
      logic        w;
      logic [4:0]  rd;
      int          sel;

      rst        = 1'b1;
      flush      = 1'b0;
      req_valid  = 1'b0;
      req_w      = 1'b0;
      req_src1   = '0;
      req_src2   = '0;
      req_rd     = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_mul_valid",  64'(mul_valid), 64'd0);
      check("rst_mul_flush",  64'(mul_flush), 64'd0);
      check("rst_resp_data",  resp_data, 64'd0);
      check("rst_resp_rd",    64'(resp_rd), 64'd0);
      check("rst_mcand",      mul_multiplicand, 64'd0);
      check("rst_mplier",     mul_multiplier, 64'd0);
      check("rst_req_ready",  64'(req_ready), 64'd1);

      // Normal MUL
      mv0 = mv_count;
      run_txn(1'b0, 64'd3, 64'd5, 5'd7, 0);
      check("mul_single_pulse", 64'(mv_count - mv0), 64'd1);

      // MULW sign extension, then same pair as MUL from the cache
      run_txn(1'b1, 64'h7FFF_FFFF, 64'd2, 5'd9, 0);
      check("mulw_value", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
      mv0 = mv_count;
      run_txn(1'b0, 64'h7FFF_FFFF, 64'd2, 5'd10, 0);
      check("cache_value", resp_data, 64'h0000_0000_FFFF_FFFE);
      check("cache_no_mul", 64'(mv_count - mv0), 64'd0);

      // Zero bypass
      mv0 = mv_count;
      run_txn(1'b0, 64'd0, 64'h1234, 5'd4, 0);
      check("zero_no_mul", 64'(mv_count - mv0), 64'd0);

      // Backpressure
      run_txn(1'b0, 64'h0000_1234_5678_9ABC, 64'hFEDC, 5'd21, 10);

      // Flush at WAIT cycle 20, then immediate restart of the multiplier
      accept_req(1'b0, 64'd100, 64'd200, 5'd2);
      repeat (21) @(negedge clk);
      flush = 1'b1;
      #1;
      check("wflush_mul_flush", 64'(mul_flush), 64'd1);
      check("wflush_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("wflush_ready_after", 64'(req_ready), 64'd1);
      check("wflush_valid_after", 64'(resp_valid), 64'd0);
      vf0 = vf_count;
      run_txn(1'b0, 64'd6, 64'd7, 5'd3, 0);
      check("restart_value", resp_data, 64'd42);
      check("restart_valid_flush", 64'(vf_count - vf0), 64'd1);

      // Reset mid-WAIT drops the cache
      run_txn(1'b0, 64'd9, 64'd11, 5'd5, 0);
      accept_req(1'b0, 64'd13, 64'd17, 5'd6);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mrst_resp_valid", 64'(resp_valid), 64'd0);
      check("mrst_mul_valid",  64'(mul_valid), 64'd0);
      check("mrst_mul_flush",  64'(mul_flush), 64'd0);
      check("mrst_resp_data",  resp_data, 64'd0);
      check("mrst_resp_rd",    64'(resp_rd), 64'd0);
      check("mrst_mcand",      mul_multiplicand, 64'd0);
      check("mrst_req_ready",  64'(req_ready), 64'd1);
      mc_valid = 1'b0;
      run_txn(1'b0, 64'd9, 64'd11, 5'd5, 0);
      check("recompute_value", resp_data, 64'd99);

      // Randomized traffic
      last_a = 64'd9;
      last_b = 64'd11;
      for (int i = 0; i < 40; i++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = '0;
         else if (sel == 1) b = '0;
         else if (sel <= 4) begin
            a = last_a;
            b = last_b;
         end else if (sel == 5) begin
            a = 64'($urandom_range(0, 255));
            b = 64'(-$signed(64'($urandom_range(1, 255))));
         end
         w  = 1'($urandom_range(0, 1));
         rd = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0)
            flush_txn(w, a, b, rd, $urandom_range(1, 80));
         else
            run_txn(w, a, b, rd, $urandom_range(0, 3));
         last_a = a;
         last_b = b;
      end

      check("valid_during_out_valid", 64'(ovl_count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/ysyx_22041207_mul_ctrl.md
Name: ysyx_22041207_mul_ctrl

Overview:
- Sequencer between the EXU and the 64-cycle iterative multiplier `ysyx_22041207_mul`.
- Accepts RV64 MUL/MULW requests over a valid/ready handshake and launches the multiplier only when it is free.
- Short-circuits zero operands and repeated operand pairs without using the multiplier.
- Applies the MULW 32-bit sign extension, holds the result under writeback backpressure, and recovers the multiplier cleanly after a pipeline flush.

Parameters:
- ZERO_BYPASS, 1: when 1, a request with src1==0 or src2==0 completes without the multiplier.
- CACHE_EN, 1: when 1, a one-entry last-operand/result cache is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush; kills any in-flight request
- req_valid  in  1  EXU request valid
- req_ready  out  1  controller can accept a request
- req_w  in  1  0=MUL, 1=MULW
- req_src1  in  64  rs1 value
- req_src2  in  64  rs2 value
- req_rd  in  5  destination register tag
- resp_valid  out  1  result valid to WB
- resp_ready  in  1  WB accepts the result
- resp_data  out  64  final rd value
- resp_rd  out  5  tag of the result
- mul_valid  out  1  start pulse to the multiplier
- mul_flush  out  1  flush line to the multiplier
- mul_multiplicand  out  64  operand a
- mul_multiplier  out  64  operand b
- mul_ready  in  1  multiplier idle
- mul_out_valid  in  1  one-cycle completion pulse; the product is final in this cycle
- mul_result_hi  in  32  product[63:32]
- mul_result_lo  in  32  product[31:0]

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values:
  - state=IDLE; resp_valid=0, mul_valid=0, mul_flush=0.
  - dirty=0, cache_valid=0.
  - resp_data, resp_rd, operand outputs = 0.
- req_ready = (state==IDLE) && !flush.
- Acceptance: at a req_valid&&req_ready edge, latch src1, src2, req_w, req_rd.
- Bypass path, checked in priority order at acceptance:
  - ZERO_BYPASS and either operand is 0: product=0, go to DONE.
  - Otherwise, CACHE_EN && cache_valid && src1==c_src1 && src2==c_src2: product=c_prod, go to DONE.
  - Otherwise go to ISSUE.
  - Bypass latency: resp_valid is high the cycle after acceptance.
- ISSUE:
  - Drive mul_multiplicand=src1 and mul_multiplier=src2, held stable until the multiplier has sampled them.
  - If dirty=0: assert mul_valid for exactly the one cycle in which mul_ready=1, then go to WAIT.
  - If dirty=1 and mul_out_valid=0: assert mul_valid and mul_flush together for one cycle, clear dirty, then go to WAIT.
  - Never assert mul_valid in a cycle where mul_out_valid=1.
- WAIT:
  - On mul_out_valid, capture product={hi,lo} and go to DONE.
  - If CACHE_EN, also write c_src1, c_src2, c_prod and set cache_valid.
  - End-to-end latency through the multiplier: resp_valid at acceptance+67 cycles.
- DONE:
  - resp_valid=1.
  - resp_data = req_w ? {{32{product[31]}},product[31:0]} : product.
  - resp_rd = latched tag.
  - resp_data and resp_rd are held stable until resp_ready; on resp_valid&&resp_ready go to IDLE.
  - A new request cannot be accepted in the same cycle as the response is taken.
- flush (highest priority, any state):
  - Next state is IDLE; resp_valid drops the next cycle; no request is accepted in the flush cycle.
  - mul_flush is asserted combinationally while flush=1.
  - If the state was ISSUE or WAIT, set dirty=1: the multiplier is left busy or stalled.
  - The cache is kept.
- A flush coinciding with mul_out_valid discards the product and leaves the cache unwritten. The multiplier returns to ready, so dirty is cleared.
- Any mul_out_valid seen outside WAIT is stale: ignore it and clear dirty.
- A flush coinciding with resp_valid&&resp_ready: the response counts as taken, and the state still goes to IDLE.

Test Plan:
- Normal MUL:
  - 3 × 5, req_w=0, rd=7 -> mul_valid is a single pulse one cycle after acceptance.
  - resp_valid at +67 with resp_data=0xF, resp_rd=7.
- MULW sign extension: 0x7FFFFFFF × 2, req_w=1 -> resp_data=0xFFFFFFFFFFFFFFFE. The same operands with req_w=0 hit the cache -> 0x00000000FFFFFFFE at +1.
- Zero bypass: 0 × 0x1234 -> resp_data=0 at acceptance+1; mul_valid never asserted.
- Flush mid-operation:
  - flush at WAIT cycle 20 -> IDLE, with req_ready high the cycle after the flush.
  - Next request 6 × 7 issues with mul_valid=mul_flush=1 in the same cycle -> resp_data=42.
- Backpressure: resp_ready held 0 for 10 cycles after resp_valid -> resp_data/resp_rd stable, req_ready=0. The result is taken on the first resp_ready cycle.
- Reset mid-WAIT: rst pulse -> all outputs at reset values the next cycle, cache_valid=0.
  - A repeat of the previous operands recomputes through the multiplier rather than hitting the cache.
